// File: rtl/oled_spi_byte_tx_if.sv
// ---------------------------------------------------------------------------
// oled_spi_byte_tx_if
//   Byte handshake between an OLED text/state sequencer (master) and the
//   SPI byte serialiser (slave).
//
//   send_data        8  byte to transmit (master -> slave)
//   send_data_valid  1  four-phase request (master -> slave)
//   send_dc_n        1  0 = command byte, 1 = display data (master -> slave)
//   send_done        1  byte shifted out; held until valid drops (slave -> master)
//   busy             1  transfer in progress (slave -> master)
// ---------------------------------------------------------------------------
interface oled_spi_byte_tx_if;
  logic [7:0] send_data;
  logic       send_data_valid;
  logic       send_dc_n;
  logic       send_done;
  logic       busy;

  modport master (
    output send_data,
    output send_data_valid,
    output send_dc_n,
    input  send_done,
    input  busy
  );

  modport slave (
    input  send_data,
    input  send_data_valid,
    input  send_dc_n,
    output send_done,
    output busy
  );
endinterface

// File: rtl/oled_spi_byte_tx.sv
// ---------------------------------------------------------------------------
// oled_spi_byte_tx
//   Accepts one byte per four-phase handshake and shifts it MSB-first onto
//   the SSD1306 SPI pins. The D/C line carries the latched send_dc_n for the
//   whole byte. send_done stays high until the producer drops valid.
//
//   Parameters
//     CLK_DIV        system clocks per SPI half-period (1..255)
//   Ports
//     clock          system clock
//     reset_n        asynchronous active-low reset
//     send_if        byte handshake (slave side)
//     oled_spi_clk   SPI clock, idles high, panel samples on rising edge
//     oled_spi_data  SPI MOSI, MSB first, changes on falling edge
//     oled_dc_n      D/C line, changes only when a byte is captured
// ---------------------------------------------------------------------------
module oled_spi_byte_tx #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  oled_spi_byte_tx_if.slave         send_if,
  output logic                      oled_spi_clk,
  output logic                      oled_spi_data,
  output logic                      oled_dc_n
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE_WAIT
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q,   state_d;
  logic [7:0] shreg_q,   shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic       lead_q,    lead_d;
  logic       done_q,    done_d;
  logic       busy_q,    busy_d;
  logic       spi_clk_q, spi_clk_d;
  logic       dc_n_q,    dc_n_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      div_cnt_q <= 8'd0;
      lead_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      spi_clk_q <= 1'b1;
      dc_n_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      lead_q    <= lead_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      spi_clk_q <= spi_clk_d;
      dc_n_q    <= dc_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    lead_d    = lead_q;
    done_d    = done_q;
    busy_d    = busy_q;
    spi_clk_d = spi_clk_q;
    dc_n_d    = dc_n_q;

    case (state_q)
      IDLE: begin
        // done_q is always low here, but keeping it in the term makes the
        // "no recapture while done is high" rule explicit.
        if (send_if.send_data_valid && !done_q) begin
          shreg_d   = send_if.send_data;
          dc_n_d    = send_if.send_dc_n;
          busy_d    = 1'b1;
          bit_cnt_d = 3'd7;
          div_cnt_d = 8'd0;
          lead_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (lead_q) begin
          // One setup cycle: MSB is already on MOSI while the clock is still
          // high, so the first falling edge opens bit 7's low phase.
          lead_d    = 1'b0;
          spi_clk_d = 1'b0;
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = 8'd0;
          if (!spi_clk_q) begin
            spi_clk_d = 1'b1;
          end else if (bit_cnt_q == 3'd0) begin
            // Last high phase over: clock stays high (idle level).
            done_d  = 1'b1;
            state_d = DONE_WAIT;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            shreg_d   = {shreg_q[6:0], 1'b0};
            spi_clk_d = 1'b0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      DONE_WAIT: begin
        if (!send_if.send_data_valid) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign send_if.send_done = done_q;
  assign send_if.busy      = busy_q;
  assign oled_spi_clk      = spi_clk_q;
  // MOSI is the top of the shift register, so it moves only when the
  // register shifts, which coincides with the falling edge.
  assign oled_spi_data     = shreg_q[7];
  assign oled_dc_n         = dc_n_q;

endmodule
